uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: byte width, matching the receiver's data_out.
REQ-002 The block SHALL have parameter DEPTH, default 16: entry count; a power of two, minimum 2.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-low reset; sampled on rising clk.
REQ-005 The block SHALL have port data_in, input, DATA_WIDTH: byte from uart_receiver data_out.
REQ-006 The block SHALL have port data_ready, input, 1: write strobe from uart_receiver; each high cycle is one byte.
REQ-007 The block SHALL have port rd_data, output, DATA_WIDTH: head-of-queue byte; valid only while rd_valid=1.
REQ-008 The block SHALL have port rd_valid, output, 1: queue non-empty.
REQ-009 The block SHALL have port rd_ready, input, 1: consumer accepts rd_data.
REQ-010 The block SHALL have port count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-011 The block SHALL have ports full and empty, output, 1 each: count==DEPTH and count==0.
REQ-012 The block SHALL have port overflow, output, 1: sticky flag for a dropped byte.
REQ-013 The block SHALL have port ovf_clear, input, 1: clears overflow.

Function
REQ-014 The block SHALL use first-word-fall-through: rd_data SHALL show the head entry combinationally from the read pointer whenever rd_valid=1.
REQ-015 A pop SHALL occur in a cycle where rd_valid && rd_ready; the read pointer advances at that edge.
REQ-016 A push SHALL occur in a cycle where data_ready && (!full || pop); data_in is written at the write pointer, which then advances.
REQ-017 Write-to-read latency SHALL be 1 cycle: a byte pushed into an empty queue raises rd_valid on the following cycle.
REQ-018 When the queue is empty, rd_ready SHALL be ignored and a simultaneous push SHALL NOT pop.
REQ-019 When full, a simultaneous push and pop SHALL both complete, leaving count at DEPTH.
REQ-020 When full, data_ready without a pop SHALL drop the byte, leave all pointers and the count unchanged, and set overflow on the next edge.
REQ-021 Pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-022 count SHALL increment on push-only, decrement on pop-only, and hold on both or neither.
REQ-023 If ovf_clear and an overflow event coincide, overflow SHALL remain 1 because set has priority.

Reset
REQ-024 While reset=0 at a rising edge, the block SHALL set both pointers=0, count=0, empty=1, full=0, rd_valid=0, and overflow=0; memory contents are don't-care.
REQ-025 Reset asserted mid-operation SHALL discard all queued bytes, and a data_ready in that same cycle SHALL be ignored.

Configuration
REQ-026 With UART_RX_FIFO_OVF_COUNT_EN defined, the block SHALL add output ovf_count[7:0], which increments per dropped byte, saturates at 255, and is zeroed by reset or ovf_clear (an increment coinciding with ovf_clear takes priority and yields 1).
REQ-027 Without UART_RX_FIFO_OVF_COUNT_EN, the ovf_count port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-028 The DATA_WIDTH default (8) and the default DEPTH SHALL be defined in the shared uart_pkg constants alongside the receiver's baud and clock constants.
REQ-029 The storage array SHALL be a sub-module, uart_rx_fifo_mem, with one synchronous write port and one asynchronous read port; pointer, count and flag logic stay in uart_rx_fifo.

Verification
REQ-030 The bench SHALL check: after reset, push 0xAA then 0x55 with rd_ready=0 -> count=2 and rd_data=0xAA; then raise rd_ready for 2 cycles -> reads 0xAA then 0x55, and empty=1.
REQ-031 The bench SHALL check: push 16 bytes 0x00..0x0F -> full=1; one more push of 0xFF -> overflow=1, count=16, and draining yields 0x00..0x0F with no 0xFF.
REQ-032 The bench SHALL check: while full, data_ready=1 with rd_ready=1 for 20 cycles on an incrementing stream -> count stays 16, overflow stays 0, and the read order is correct across pointer wrap.
REQ-033 The bench SHALL check: push 0x3C into empty with rd_ready=1 held -> rd_valid=0 in the push cycle, rd_valid=1 with 0x3C the next cycle, and empty again after.
REQ-034 The bench SHALL check: 5 bytes queued, then reset=0 for one cycle with data_ready=1 -> count=0, rd_valid=0, and overflow=0.
REQ-035 With UART_RX_FIFO_OVF_COUNT_EN defined, the bench SHALL check: 300 pushes into a full queue -> ovf_count=255; then ovf_clear -> ovf_count=0 and overflow=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants shared by the UART receive path: receiver clock and baud setup, and
// receive-FIFO defaults. Also holds the FIFO's per-cycle operation encoding.
package uart_pkg;

    localparam int CLK_FREQ_HZ  = 50_000_000;
    localparam int BAUD_RATE    = 115_200;
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    localparam int RX_FIFO_DATA_WIDTH = 8;
    localparam int RX_FIFO_DEPTH      = 16;

    // Bit order is {push, pop}, so the enum can be cast straight from the two strobes.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for uart_rx_fifo: one synchronous write port and one
// asynchronous read port, so the head byte is visible without a read cycle.
module uart_rx_fifo_mem #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; the empty flag guarantees stale entries are never read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with a sticky overflow flag.
// Define UART_RX_FIFO_OVF_COUNT_EN to add a saturating 8-bit dropped-byte counter, ovf_count.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = RX_FIFO_DATA_WIDTH,
    parameter  int DEPTH      = RX_FIFO_DEPTH,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
`ifdef UART_RX_FIFO_OVF_COUNT_EN
    output logic [7:0]            ovf_count,
`endif
    input  logic                  ovf_clear
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;
    fifo_op_e      op;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign rd_valid = !empty;

    // A pop frees the slot the simultaneous push needs, so a full queue still streams.
    assign pop  = rd_valid && rd_ready;
    assign push = data_ready && (!full || pop);
    assign drop = data_ready && full && !pop;
    assign op   = fifo_op_e'({push, pop});

    uart_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && reset),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case (op)
                OP_PUSH: count <= count + 1'b1;
                OP_POP:  count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Set beats clear so a byte lost in the clearing cycle is still reported.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_OVF_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_count <= '0;
        end else if (drop) begin
            if (ovf_clear) begin
                ovf_count <= 8'd1;
            end else if (ovf_count != 8'hFF) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end else if (ovf_clear) begin
            ovf_count <= '0;
        end
    end
`endif

endmodule
